// File: rtl/alu_unit_if.sv
// Operand/result bundle between the operand registers and the ALU.
// The master side drives operands and the slave side returns result and flags.
interface alu_unit_if #(
    parameter int SIZE = 32
);
    logic            in_valid;
    logic [SIZE-1:0] A;
    logic [SIZE-1:0] B;
    logic [1:0]      CTRL;
    logic            out_valid;
    logic [SIZE:0]   R;
    logic            O;
    logic            Z;
    logic            N;

    modport master (
        output in_valid, A, B, CTRL,
        input  out_valid, R, O, Z, N
    );

    modport slave (
        input  in_valid, A, B, CTRL,
        output out_valid, R, O, Z, N
    );
endinterface

// File: rtl/alu_unit.sv
// Registered ADD/SUB/AND/OR unit with carry/borrow, zero and negative flags.
// Combinational op logic feeds output registers for one-cycle latency.
module alu_unit #(
    parameter int SIZE = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_unit_if.slave bus
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic [SIZE:0] res;
    logic          res_o;
    logic          res_n;

    // Operands are zero-extended so bit SIZE carries the unsigned carry or borrow.
    always_comb begin
        res   = '0;
        res_o = 1'b0;
        res_n = 1'b0;
        case (bus.CTRL)
            OP_ADD: begin
                res   = {1'b0, bus.A} + {1'b0, bus.B};
                res_o = res[SIZE];
                res_n = res[SIZE-1];
            end
            OP_SUB: begin
                res   = {1'b0, bus.A} - {1'b0, bus.B};
                res_o = res[SIZE];
                res_n = res[SIZE-1];
            end
            OP_AND: res = {1'b0, bus.A & bus.B};
            OP_OR:  res = {1'b0, bus.A | bus.B};
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.R         <= '0;
            bus.O         <= 1'b0;
            bus.Z         <= 1'b0;
            bus.N         <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.R <= res;
                bus.O <= res_o;
                bus.Z <= ~|res[SIZE-1:0];
                bus.N <= res_n;
            end
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit: op results, flags, hold and reset behaviour.
module tb_alu_unit;

    localparam int SIZE = 32;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_failed;

    alu_unit_if #(.SIZE(SIZE)) bus ();

    alu_unit #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [SIZE:0] r, input logic o,
                             input logic z, input logic n, input logic v);
        check({tag, ".R"},  64'(bus.R), 64'(r));
        check({tag, ".O"},  64'(bus.O), 64'(o));
        check({tag, ".Z"},  64'(bus.Z), 64'(z));
        check({tag, ".N"},  64'(bus.N), 64'(n));
        check({tag, ".V"},  64'(bus.out_valid), 64'(v));
    endtask

    // Drive one op at the falling edge, sample just after the capturing edge.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [32:0] r, input logic o,
                          input logic z, input logic n);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.CTRL     = op;
        bus.A        = a;
        bus.B        = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_out(tag, r, o, z, n, 1'b1);
    endtask

    initial begin
        n_tests      = 0;
        n_failed     = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.CTRL     = 2'b00;

        #2;
        check_out("rst_async", 33'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("rst_hold", 33'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_carry", 2'b00, 32'hFFFFF000, 32'hFFFFFFFF, 33'h1FFFFEFFF, 1'b1, 1'b0, 1'b1);
        run_op("add_plain", 2'b00, 32'h67676767, 32'h12431243, 33'h079AA79AA, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap",  2'b00, 32'hFFFFFFFF, 32'h00000001, 33'h100000000, 1'b1, 1'b1, 1'b0);
        run_op("sub_zero",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 33'h000000000, 1'b0, 1'b1, 1'b0);
        run_op("sub_borrow",2'b01, 32'hFFFFF000, 32'hFFFFFFFF, 33'h1FFFFF001, 1'b1, 1'b0, 1'b1);
        run_op("and_mix",   2'b10, 32'hABCD4545, 32'h12383588, 33'h002080500, 1'b0, 1'b0, 1'b0);
        run_op("and_msb",   2'b10, 32'hF0F0F0F0, 32'hCFCFCFCF, 33'h0C0C0C0C0, 1'b0, 1'b0, 1'b0);
        run_op("and_zero",  2'b10, 32'h00000000, 32'h11000001, 33'h000000000, 1'b0, 1'b1, 1'b0);
        run_op("or_ones",   2'b11, 32'hFFFFFFFF, 32'h0A0AB0B0, 33'h0FFFFFFFF, 1'b0, 1'b0, 1'b0);
        run_op("or_mix",    2'b11, 32'h00000000, 32'h11000001, 33'h011000001, 1'b0, 1'b0, 1'b0);

        // Idle cycles with stale operands on the bus: results must hold.
        bus.A    = 32'h12345678;
        bus.B    = 32'h0;
        bus.CTRL = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_out($sformatf("idle%0d", i), 33'h011000001, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Back-to-back ops then a drop in valid.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.CTRL     = 2'b00;
        bus.A        = 32'h00000001;
        bus.B        = 32'h00000002;
        @(posedge clk);
        #1;
        check_out("b2b_0", 33'h000000003, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.CTRL = 2'b01;
        bus.A    = 32'h00000001;
        bus.B    = 32'h00000002;
        @(posedge clk);
        #1;
        check_out("b2b_1", 33'h1FFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_out("pulse_end", 33'h1FFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset mid-stream with an op pending: outputs clear at once, result discarded.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.CTRL     = 2'b11;
        bus.A        = 32'h0000FFFF;
        bus.B        = 32'h00000000;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst_mid", 33'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("rst_edge", 33'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("post_rst", 33'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op("first_op", 2'b11, 32'h0000FFFF, 32'h00000000, 33'h00000FFFF, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Registered SIZE-bit two's-complement ALU performing ADD, SUB, bitwise AND and bitwise OR, selected by a 2-bit opcode.
- Produces a SIZE+1-bit result plus overflow/carry (O), zero (Z) and negative (N) flags.
- Sits in the datapath between the operand registers and the writeback/flag logic.
- Inputs are sampled on a valid strobe; results and flags are registered with one-cycle latency.

Parameters:
- SIZE, 32, operand width in bits; result width is SIZE+1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/opcode valid this cycle
- A  input  SIZE  operand A, signed
- B  input  SIZE  operand B, signed
- CTRL  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR
- out_valid  output  1  R and flags valid (registered)
- R  output  SIZE+1  result; bit SIZE is carry/borrow
- O  output  1  carry-out (ADD) / borrow (SUB); 0 for logic ops
- Z  output  1  1 when R[SIZE-1:0] == 0
- N  output  1  R[SIZE-1] for ADD/SUB; 0 for logic ops

Behaviour:
- Reset: rst_n low asynchronously clears R, O, Z, N and out_valid to 0, regardless of clk. Outputs hold 0 until the first accepted operation after rst_n deasserts.
- Acceptance: on a rising clk edge with rst_n high and in_valid=1, A/B/CTRL are evaluated. R/O/Z/N update at that edge and out_valid=1. Latency is 1 cycle; throughput is one op per cycle, back-to-back.
- in_valid=0 at an edge: R/O/Z/N hold their previous values; out_valid=0.
- ADD (00): R = {1'b0,A} + {1'b0,B}, an unsigned SIZE+1-bit sum. O = R[SIZE] (carry-out).
- SUB (01): R = {1'b0,A} - {1'b0,B} mod 2^(SIZE+1). R[SIZE]=1 exactly when A < B unsigned (borrow). O = R[SIZE].
- AND (10): R = {1'b0, A & B}; O = 0.
- OR (11): R = {1'b0, A | B}; O = 0.
- Z = ~|R[SIZE-1:0] for every opcode; bit SIZE is ignored.
- N = R[SIZE-1] for ADD/SUB; forced 0 for AND/OR.
- No saturation. Wrap-around is modulo 2^SIZE in R[SIZE-1:0].
- X/undefined CTRL never arises; all four codes are defined.
- Reset asserted mid-stream: the pending result is discarded and outputs go to 0 immediately.
- Reset deassertion is synchronised by the integrator. The block's first capture occurs on the first edge after rst_n is high.
- Implementation is purely registered outputs fed by combinational op logic. There are no internal state machines.

Test Plan:
- ADD A=FFFFF000, B=FFFFFFFF -> R[31:0]=FFFFEFFF, R[32]=1, O=1, Z=0, N=1. Also A=67676767, B=12431243 -> 79AA79AA, O=0, N=0, Z=0.
- ADD A=FFFFFFFF, B=00000001 -> R[31:0]=00000000, O=1, Z=1, N=0.
- SUB A=FFFFFFFF, B=FFFFFFFF -> R=0, O=0, Z=1, N=0. Also A=FFFFF000, B=FFFFFFFF -> R[31:0]=FFFFF001, O=1, N=1, Z=0.
- AND A=ABCD4545, B=12383588 -> 02080500, O=0, N=0. Also A=F0F0F0F0, B=CFCFCFCF -> C0C0C0C0, N=0. Also A=00000000, B=11000001 -> 0, Z=1.
- OR A=FFFFFFFF, B=0A0AB0B0 -> FFFFFFFF, N=0, O=0. Also A=00000000, B=11000001 -> 11000001, Z=0.
- Reset/handshake:
  - Drive rst_n low between edges -> all outputs 0 immediately.
  - in_valid=0 for 3 cycles -> R/flags hold, out_valid=0.
  - in_valid pulse -> result on the next edge with out_valid high for exactly that cycle.
